// File: rtl/rx_frame_controller_if.sv
// Receiver byte stream and downstream valid/ready payload stream of the frame controller.
interface rx_frame_controller_if;
    logic       byte_valid;
    logic [7:0] byte_in;
    logic       rcv_reset;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    modport slave (
        input  byte_valid, byte_in, out_ready,
        output rcv_reset, out_valid, out_data, out_last
    );

    modport master (
        output byte_valid, byte_in, out_ready,
        input  rcv_reset, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rx_frame_controller.sv
// Assembles LEN/payload/CHK frames from the receiver byte stream, verifies the XOR checksum,
// and only then releases the buffered payload downstream; errors and gaps resync the receiver.
//
// state     | meaning
// S_IDLE    | waiting for LEN byte
// S_PAYLOAD | collecting LEN payload bytes into buffer
// S_CHECK   | waiting for CHK byte
// S_DELIVER | streaming buffered payload over valid/ready
// S_DROP    | single-cycle error report and receiver reset
module rx_frame_controller #(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 1024,
    parameter int IDX_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    rx_frame_controller_if.slave        bus,
    output logic                        o_frame_ok,
    output logic                        o_frame_err,
    output logic [1:0]                  o_err_code,
    output logic [7:0]                  o_ovr_cnt
);
    localparam int BUF_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GAP_W = $clog2(TIMEOUT);
    localparam logic [8:0]       MAX_LEN_V = 9'(MAX_LEN);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CHECK,
        S_DELIVER,
        S_DROP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_len;
    logic [7:0]        r_csum;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_rd;
    logic [GAP_W-1:0]  r_gap;
    logic [7:0]        r_buf [2**BUF_W];
    logic              r_frame_ok;
    logic [1:0]        r_err_code;
    logic [7:0]        r_ovr_cnt;

    logic [7:0]        w_len_m1;
    logic              w_len_bad;
    logic              w_last_idx;
    logic              w_rd_last;
    logic              w_xfer;
    logic              w_gap_tc;
    logic              w_set_code;
    logic [1:0]        w_code;

    assign w_len_m1   = r_len - 8'd1;
    assign w_len_bad  = (bus.byte_in == 8'd0) || ({1'b0, bus.byte_in} > MAX_LEN_V);
    assign w_last_idx = (r_idx == IDX_W'(w_len_m1));
    assign w_rd_last  = (r_rd == IDX_W'(w_len_m1));
    assign w_xfer     = bus.out_valid && bus.out_ready;
    assign w_gap_tc   = (r_gap == '0);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_set_code = 1'b0;
        w_code     = 2'd0;
        case (r_state)
            S_IDLE: begin
                if (bus.byte_valid) begin
                    if (w_len_bad) begin
                        w_next     = S_DROP;
                        w_set_code = 1'b1;
                        w_code     = 2'd1;
                    end else begin
                        w_next = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (bus.byte_valid) begin
                    if (w_last_idx) w_next = S_CHECK;
                end else if (w_gap_tc) begin
                    w_next     = S_DROP;
                    w_set_code = 1'b1;
                    w_code     = 2'd3;
                end
            end
            S_CHECK: begin
                if (bus.byte_valid) begin
                    if (bus.byte_in == r_csum) begin
                        w_next = S_DELIVER;
                    end else begin
                        w_next     = S_DROP;
                        w_set_code = 1'b1;
                        w_code     = 2'd2;
                    end
                end else if (w_gap_tc) begin
                    w_next     = S_DROP;
                    w_set_code = 1'b1;
                    w_code     = 2'd3;
                end
            end
            S_DELIVER: begin
                if (w_xfer && w_rd_last) w_next = S_IDLE;
            end
            S_DROP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len      <= '0;
            r_csum     <= '0;
            r_idx      <= '0;
            r_rd       <= '0;
            r_gap      <= GAP_LOAD;
            r_frame_ok <= 1'b0;
            r_err_code <= 2'd0;
            r_ovr_cnt  <= '0;
        end else begin
            r_frame_ok <= (r_state == S_CHECK) && (w_next == S_DELIVER);
            if (w_set_code) r_err_code <= w_code;

            if (r_state == S_IDLE && bus.byte_valid) begin
                r_len  <= bus.byte_in;
                r_csum <= bus.byte_in;
            end else if (r_state == S_PAYLOAD && bus.byte_valid) begin
                r_csum <= r_csum ^ bus.byte_in;
            end

            // index saturates at LEN-1 so it never points past the frame
            if (r_state == S_IDLE)
                r_idx <= '0;
            else if (r_state == S_PAYLOAD && bus.byte_valid && !w_last_idx)
                r_idx <= r_idx + 1'b1;

            if (r_state != S_DELIVER)
                r_rd <= '0;
            else if (w_xfer && !w_rd_last)
                r_rd <= r_rd + 1'b1;

            if (bus.byte_valid || r_state == S_IDLE)
                r_gap <= GAP_LOAD;
            else if (!w_gap_tc)
                r_gap <= r_gap - 1'b1;

            if (bus.byte_valid && (r_state == S_DELIVER || r_state == S_DROP) && r_ovr_cnt != 8'hFF)
                r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_PAYLOAD && bus.byte_valid)
            r_buf[r_idx[BUF_W-1:0]] <= bus.byte_in;
    end

    assign bus.out_valid = (r_state == S_DELIVER);
    assign bus.out_data  = bus.out_valid ? r_buf[r_rd[BUF_W-1:0]] : 8'd0;
    assign bus.out_last  = bus.out_valid && w_rd_last;
    assign bus.rcv_reset = (r_state == S_DROP);
    assign o_frame_err   = (r_state == S_DROP);
    assign o_frame_ok    = r_frame_ok;
    assign o_err_code    = r_err_code;
    assign o_ovr_cnt     = r_ovr_cnt;
endmodule

// File: tb/tb_rx_frame_controller.sv
// Directed-vector bench for rx_frame_controller: good frames, stalls, bad LEN/CHK,
// inter-byte timeout and its expiry-cycle boundary, overrun counting and mid-frame reset.
module tb_rx_frame_controller;
    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] ovr_cnt;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    rx_frame_controller_if bus ();

    rx_frame_controller #(
        .MAX_LEN (MAX_LEN),
        .TIMEOUT (TIMEOUT),
        .IDX_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .o_frame_ok (frame_ok),
        .o_frame_err(frame_err),
        .o_err_code (err_code),
        .o_ovr_cnt  (ovr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    // stall=1 drives out_ready as 1,0,0,1,0,0,...
    task automatic deliver(input string tag, input int stall, input int cyc_exp);
        int   k;
        int   cyc;
        logic xfer;
        k   = 0;
        cyc = 0;
        while (k < exp_q.size() && cyc < 40) begin
            check({tag, "_valid"}, int'(bus.out_valid), 1);
            check({tag, "_data"}, int'(bus.out_data), int'(exp_q[k]));
            check({tag, "_last"}, int'(bus.out_last), int'(k == exp_q.size() - 1));
            check({tag, "_fok"}, int'(frame_ok), int'(cyc == 0));
            bus.out_ready = (stall != 0) ? ((cyc % 3) == 0) : 1'b1;
            xfer = bus.out_valid && bus.out_ready;
            tick();
            cyc++;
            if (xfer) k++;
        end
        bus.out_ready = 1'b1;
        check({tag, "_count"}, k, exp_q.size());
        check({tag, "_cycles"}, cyc, cyc_exp);
        check({tag, "_idle"}, int'(bus.out_valid), 0);
    endtask

    initial begin
        int gap;
        reset          = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        bus.out_ready  = 1'b1;
        repeat (3) tick();
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_data", int'(bus.out_data), 0);
        check("rst_last", int'(bus.out_last), 0);
        check("rst_rcv", int'(bus.rcv_reset), 0);
        check("rst_fok", int'(frame_ok), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_code", int'(err_code), 0);
        check("rst_ovr", int'(ovr_cnt), 0);
        reset = 1'b0;
        tick();

        // good frame, out_ready held high
        send_byte(8'h03); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
        send_byte(8'hD3);
        exp_q = '{8'hA1, 8'hB2, 8'hC3};
        deliver("t1", 0, 3);

        // same frame with downstream stalls
        send_byte(8'h03); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
        send_byte(8'hD3);
        deliver("t2", 1, 7);

        // LEN = 0 and LEN = MAX_LEN+1
        send_byte(8'h00);
        check("t3_len0_err", int'(frame_err), 1);
        check("t3_len0_code", int'(err_code), 1);
        check("t3_len0_rcv", int'(bus.rcv_reset), 1);
        tick();
        check("t3_len0_pulse", int'(frame_err), 0);
        check("t3_len0_rcv_pulse", int'(bus.rcv_reset), 0);
        check("t3_code_hold", int'(err_code), 1);
        send_byte(8'(MAX_LEN + 1));
        check("t3_lenbig_err", int'(frame_err), 1);
        check("t3_lenbig_code", int'(err_code), 1);
        check("t3_lenbig_rcv", int'(bus.rcv_reset), 1);
        tick();
        send_byte(8'h02); send_byte(8'h5A); send_byte(8'hA5); send_byte(8'hFD);
        exp_q = '{8'h5A, 8'hA5};
        deliver("t3_good", 0, 2);

        // bad checksum
        send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h00);
        check("t4_err", int'(frame_err), 1);
        check("t4_code", int'(err_code), 2);
        check("t4_fok", int'(frame_ok), 0);
        check("t4_valid", int'(bus.out_valid), 0);
        tick();
        check("t4_valid_after", int'(bus.out_valid), 0);
        check("t4_code_hold", int'(err_code), 2);

        // inter-byte timeout
        send_byte(8'h04); send_byte(8'hAA); send_byte(8'hBB);
        gap = 0;
        for (int i = 1; i <= TIMEOUT + 4; i++) begin
            tick();
            if (frame_err) begin
                gap = i;
                break;
            end
        end
        check("t5_gap", gap, TIMEOUT - 1);
        check("t5_code", int'(err_code), 3);
        check("t5_rcv", int'(bus.rcv_reset), 1);
        tick();

        // byte landing in the expiry cycle is accepted
        send_byte(8'h04); send_byte(8'hAA); send_byte(8'hBB);
        repeat (TIMEOUT - 2) tick();
        send_byte(8'hCC);
        check("t5b_no_err", int'(frame_err), 0);
        send_byte(8'hDD);
        check("t5b_no_err2", int'(frame_err), 0);
        send_byte(8'h04);
        exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        deliver("t5b", 0, 4);

        // overrun bytes during a stalled delivery
        check("t6_ovr_pre", int'(ovr_cnt), 0);
        send_byte(8'h01); send_byte(8'h7E);
        bus.out_ready = 1'b0;
        send_byte(8'h7F);
        check("t6_fok", int'(frame_ok), 1);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
        check("t6_ovr", int'(ovr_cnt), 3);
        check("t6_valid", int'(bus.out_valid), 1);
        check("t6_data", int'(bus.out_data), 8'h7E);
        check("t6_last", int'(bus.out_last), 1);
        bus.out_ready = 1'b1;
        tick();
        check("t6_done", int'(bus.out_valid), 0);
        check("t6_ovr_hold", int'(ovr_cnt), 3);

        // reset in the middle of a payload
        send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_fok", int'(frame_ok), 0);
        check("t7_ferr", int'(frame_err), 0);
        check("t7_ovr_clr", int'(ovr_cnt), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t7_quiet", int'(frame_err | frame_ok), 0);
        end
        send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
        exp_q = '{8'h42};
        deliver("t7_good", 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
